mac_acc_pipe: RTL
=================

// Module: mac_acc_pipe
// PURPOSE
//  N-lane dot-product MAC with internal accumulator and valid/ready handshake on both sides.
//  Each beat multiplies col unsigned activations by col signed weights, sums the products and accumulates.
//  After acc_len beats it emits one psum.
//  Successor to mac_wrapper: parametrised lane count, 2-stage pipeline, multi-beat accumulation, backpressure.
// PARAMETERS
//  bw       4   activation/weight width per lane
//  psum_bw  16  accumulator/output width; must be >= 2*bw+1+$clog2(col)
//  col      4   number of lanes
//  len_bw   8   width of acc_len
// PORTS
//  clk       in   1           rising-edge clock
//  reset_n   in   1           async active-low reset
//  in_valid  in   1           x_in/w_in/psum_in/acc_len valid
//  in_ready  out  1           beat accepted when in_valid && in_ready
//  x_in      in   col*bw      lane k = x_in[k*bw +: bw], unsigned
//  w_in      in   col*bw      lane k = w_in[k*bw +: bw], signed 2's complement
//  psum_in   in   psum_bw     signed initial value; sampled on the first beat of a group only
//  acc_len   in   len_bw      beats per group; sampled on the first beat; 0 treated as 1
//  out_valid out  1           out holds a completed group result
//  out_ready in   1           result consumed when out_valid && out_ready
//  out       out  psum_bw     signed accumulated result
//  busy      out  1           group in progress or result pending
// BEHAVIOUR
//  Reset (async, reset_n=0): all state cleared.
//   - out_valid=0, out=0, busy=0, in_ready=1 after release.
//   - Pipeline valids, counter and accumulator = 0; FSM returns to IDLE.
//   - A partial group is discarded.
//  Stall: stall = out_valid && !out_ready. in_ready = !stall.
//   - While stalled, every pipeline register and the counter hold.
//   - A completing group can never overwrite an unconsumed result.
//  Stage 1 (accept cycle): per lane, p_k = $signed({1'b0,x_k}) * $signed(w_k), 2*bw+1 bits, registered.
//   - First-beat flag, psum_in and acc_len are registered alongside.
//  Stage 2: sum = sign-extended adder tree of the p_k.
//   - First beat: acc = psum_in + sum. Other beats: acc = acc + sum.
//  FSM on stage-2 valid:
//   - IDLE -> ACC on the first beat; cnt=1, len latched (0 becomes 1).
//   - ACC: cnt++ per beat. When cnt reaches len, out <= final acc, out_valid <= 1, FSM -> IDLE.
//   - When len==1 the first beat completes immediately: IDLE -> IDLE with output loaded.
//  Latency: final beat accepted at edge t -> out_valid=1 after edge t+2.
//   - Throughput is 1 beat/clk with no bubble between back-to-back groups.
//  out_valid clears on the edge where out_ready=1.
//   - Simultaneous consume and new completion on the same edge: the new result loads and out_valid stays 1.
//  acc_len, psum_in mid-group: ignored except on a group's first beat.
//  busy = (FSM==ACC) || any stage valid || out_valid.
//  Arithmetic without the optional feature wraps modulo 2^psum_bw.
// CONFIGURATION
//  MAC_ACC_SAT_EN defined: each accumulate step saturates.
//   - Clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1]; sticky sat_flag output (1 bit) is added.
//   - sat_flag is set when any clamp occurs in the group and is cleared on the next group's first beat and on reset.
//  MAC_ACC_SAT_EN undefined: two's-complement wrap; no sat_flag port.
// TESTING
//  1. acc_len=1, psum_in=0, x={1,2,3,4}, w={1,-1,2,-2}:
//     -> out=-3 (0xFFFD), out_valid 2 clk after accept.
//  2. acc_len=5, psum_in=10, five beats of x={15,15,15,15}, w={-8,-8,-8,-8}:
//     -> out=10-2400=-2390 (0xF6AA).
//  3. Back-to-back groups, acc_len=2, with out_ready=1 throughout:
//     -> in_ready stays 1; one result every 2 clk.
//  4. out_ready=0 while result pending, in_valid=1:
//     -> in_ready=0 next cycle, out held stable.
//     Release out_ready -> accept resumes, no beat lost or duplicated.
//  5. reset_n=0 after 3 of 5 beats:
//     -> out_valid=0, busy=0 immediately.
//     Next group (acc_len=1, x=1, w=1, psum_in=0) -> out=1.
//  6. MAC_ACC_SAT_EN: psum_in=32760, acc_len=1, x={15,0,0,0}, w={7,0,0,0}:
//     -> out=32767, sat_flag=1.
//     Without the macro -> out=-32671 (0x8061).

Source files
------------

// File: rtl/mac_acc_pipe.sv
// mac_acc_pipe: N-lane dot-product MAC with a multi-beat accumulator.
// Two register stages (products, lane sum), then accumulate and emit.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   in_valid/in_ready    input beat handshake
//   x_in                 col unsigned activations, lane k at [k*bw +: bw]
//   w_in                 col signed weights, lane k at [k*bw +: bw]
//   psum_in, acc_len     group seed and beat count (first beat only)
//   out_valid/out_ready  result handshake
//   out                  signed accumulated group result
//   busy                 group in flight or result pending
//   sat_flag             sticky clamp indicator (MAC_ACC_SAT_EN only)
//
// Build option: define MAC_ACC_SAT_EN for saturating accumulation.
// Without it the accumulator wraps modulo 2^psum_bw.
module mac_acc_pipe #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 4,
  parameter int len_bw  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [col*bw-1:0]     x_in,
  input  logic [col*bw-1:0]     w_in,
  input  logic [psum_bw-1:0]    psum_in,
  input  logic [len_bw-1:0]     acc_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [psum_bw-1:0]    out,
  output logic                  busy
`ifdef MAC_ACC_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int PW = 2*bw + 1;
  localparam int SW = PW + $clog2(col);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  localparam logic [len_bw-1:0] LEN_ONE = len_bw'(1);

  logic stall;
  logic accept;

  // input-side group tracker
  logic [len_bw-1:0] rem_q;
  logic [len_bw-1:0] rem_d;
  logic              in_first;
  logic [len_bw-1:0] in_len;

  // stage 1
  logic                      s1_vld_q;
  logic                      s1_first_q;
  logic [psum_bw-1:0]        s1_psum_q;
  logic [len_bw-1:0]         s1_len_q;
  logic signed [PW-1:0]      s1_p_q [col];
  logic signed [PW-1:0]      prod   [col];

  // stage 2
  logic                      s2_vld_q;
  logic                      s2_first_q;
  logic [psum_bw-1:0]        s2_psum_q;
  logic [len_bw-1:0]         s2_len_q;
  logic signed [SW-1:0]      s2_sum_q;
  logic signed [SW-1:0]      sum_c;

  // accumulate / output
  logic [0:0]                state_q;
  logic [0:0]                state_d;
  logic [len_bw-1:0]         cnt_q;
  logic [len_bw-1:0]         cnt_d;
  logic [len_bw-1:0]         len_q;
  logic [len_bw-1:0]         len_d;
  logic [psum_bw-1:0]        acc_q;
  logic [psum_bw-1:0]        acc_d;
  logic [psum_bw-1:0]        out_q;
  logic [psum_bw-1:0]        out_d;
  logic                      ov_q;
  logic                      ov_d;
  logic                      sat_q;
  logic                      sat_d;

  logic signed [psum_bw-1:0] base;
  logic signed [psum_bw-1:0] sum_x;
  logic signed [psum_bw-1:0] step;
  logic                      ovf;
  logic [len_bw-1:0]         len_eff;
  logic                      done;

  // ---------------- handshake ----------------
  assign stall    = ov_q && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // ---------------- group tracker ----------------
  // rem_q counts beats still owed to the open group;
  // zero means the next accepted beat opens a group.
  assign in_first = (rem_q == '0);
  assign in_len   = (acc_len == '0) ? LEN_ONE : acc_len;

  always_comb begin
    rem_d = rem_q;
    if (accept) begin
      if (in_first) rem_d = in_len - LEN_ONE;
      else          rem_d = rem_q - LEN_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rem_q <= '0;
    else          rem_q <= rem_d;
  end

  // ---------------- stage 1: lane products ----------------
  always_comb begin
    for (int k = 0; k < col; k++) begin
      prod[k] = $signed({1'b0, x_in[k*bw +: bw]})
              * $signed(w_in[k*bw +: bw]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_psum_q  <= '0;
      s1_len_q   <= '0;
      for (int k = 0; k < col; k++) s1_p_q[k] <= '0;
    end else if (!stall) begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_first_q <= in_first;
        s1_psum_q  <= psum_in;
        s1_len_q   <= acc_len;
        for (int k = 0; k < col; k++) s1_p_q[k] <= prod[k];
      end
    end
  end

  // ---------------- stage 2: lane sum ----------------
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < col; k++) begin
      sum_c = sum_c + SW'(s1_p_q[k]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_psum_q  <= '0;
      s2_len_q   <= '0;
      s2_sum_q   <= '0;
    end else if (!stall) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_first_q <= s1_first_q;
        s2_psum_q  <= s1_psum_q;
        s2_len_q   <= s1_len_q;
        s2_sum_q   <= sum_c;
      end
    end
  end

  // ---------------- accumulate step ----------------
  assign base  = s2_first_q ? $signed(s2_psum_q) : $signed(acc_q);
  assign sum_x = psum_bw'(s2_sum_q);

`ifdef MAC_ACC_SAT_EN
  localparam logic signed [psum_bw-1:0] SMAX =
    {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] SMIN =
    {1'b1, {(psum_bw-1){1'b0}}};

  logic signed [psum_bw:0] wide;

  // one guard bit: top two bits differ on overflow
  assign wide = {base[psum_bw-1], base}
              + {sum_x[psum_bw-1], sum_x};
  assign ovf  = wide[psum_bw] != wide[psum_bw-1];
  assign step = !ovf         ? wide[psum_bw-1:0]
              : wide[psum_bw] ? SMIN
              :                 SMAX;
`else
  assign ovf  = 1'b0;
  assign step = base + sum_x;
`endif

  // ---------------- group FSM ----------------
  assign len_eff = (s2_len_q == '0) ? LEN_ONE : s2_len_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ov_d    = ov_q;
    sat_d   = sat_q;
    done    = 1'b0;

    if (ov_q && out_ready) ov_d = 1'b0;

    if (!stall && s2_vld_q) begin
      acc_d = step;
      if (s2_first_q) begin
        len_d = len_eff;
        cnt_d = LEN_ONE;
        done  = (len_eff == LEN_ONE);
        sat_d = ovf;
      end else begin
        cnt_d = cnt_q + LEN_ONE;
        done  = (cnt_d == len_q);
        sat_d = sat_q | ovf;
      end

      unique case (1'b1)
        done: begin
          out_d   = step;
          ov_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      sat_q   <= sat_d;
    end
  end

  // ---------------- outputs ----------------
  assign out       = out_q;
  assign out_valid = ov_q;
  assign busy      = (state_q == S_ACC) | s1_vld_q
                   | s2_vld_q | ov_q;

`ifdef MAC_ACC_SAT_EN
  assign sat_flag = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q ^ ovf;
`endif

endmodule
